// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array stream front-end.
package systolic_pkg;

  typedef enum logic [4:0] {
    IDLE_S   = 5'b00001,
    LOAD_S   = 5'b00010,
    SETTLE_S = 5'b00100,
    DRAIN_S  = 5'b01000,
    CLEAR_S  = 5'b10000
  } state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/onehot_counter.sv
// Rotating one-hot selector; last_o flags the final position before wrap.
module onehot_counter #(
  parameter int unsigned n_p = 2
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           clear_i,
  input  logic           adv_i,
  output logic [n_p-1:0] onehot_o,
  output logic           last_o
);

  logic [n_p-1:0] onehot_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      onehot_q <= n_p'(1);
    end else if (adv_i) begin
      onehot_q <= {onehot_q[n_p-2:0], onehot_q[n_p-1]};
    end
  end

  assign onehot_o = onehot_q;
  assign last_o   = onehot_q[n_p-1];

endmodule

// File: rtl/systolic_stream_driver.sv
// Streams operand words into a systolic array, waits for it to settle,
// drains the MAC results in row-major order and clears the array.
module systolic_stream_driver
  import systolic_pkg::*;
#(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned depth_p        = 2,
  parameter int unsigned settle_p       = 8
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic                                              flush_i,
  input  logic                                              valid_i,
  output logic                                              ready_o,
  input  logic [width_p-1:0]                                data_i,
  output logic                                              valid_o,
  input  logic                                              yumi_i,
  output logic [width_p-1:0]                                data_o,
  output logic                                              busy_o,
  output logic [width_p*array_height_p-1:0]                 row_o,
  output logic [array_height_p-1:0]                         row_valid_o,
  input  logic [array_height_p-1:0]                         row_ready_i,
  output logic [width_p*array_width_p-1:0]                  col_o,
  output logic [array_width_p-1:0]                          col_valid_o,
  input  logic [array_width_p-1:0]                          col_ready_i,
  input  logic [width_p*array_width_p*array_height_p-1:0]   z_i,
  output logic                                              array_reset_o
);

  localparam int unsigned num_lp      = array_width_p * array_height_p;
  localparam int unsigned sel_n_lp    = array_height_p + array_width_p;
  localparam int unsigned step_w_lp   = idx_width(depth_p);
  localparam int unsigned settle_w_lp = idx_width(settle_p);
  localparam int unsigned idx_w_lp    = idx_width(num_lp);

  state_e                 state_q, state_n;
  logic [step_w_lp-1:0]   step_q, step_n;
  logic [settle_w_lp-1:0] settle_q, settle_n;
  logic [idx_w_lp-1:0]    idx_q, idx_n;
  logic [sel_n_lp-1:0]    sel_onehot;
  logic                   sel_last;
  logic                   sel_adv, sel_clr;
  logic                   sel_ready, loading, accept, yumi_ok, live;
  logic [width_p-1:0]     z_arr [num_lp];

  onehot_counter #(.n_p(sel_n_lp)) u_sel (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (en_i & sel_clr),
    .adv_i    (en_i & sel_adv),
    .onehot_o (sel_onehot),
    .last_o   (sel_last)
  );

  for (genvar g = 0; g < num_lp; g++) begin : g_z
    assign z_arr[g] = z_i[g*width_p +: width_p];
  end

  // Handshakes are only live on enabled, non-reset cycles.
  assign live      = en_i & ~reset_i;
  assign sel_ready = |(sel_onehot & {col_ready_i, row_ready_i});
  assign loading   = (state_q == IDLE_S) || (state_q == LOAD_S);
  assign ready_o   = live & loading & sel_ready;
  assign accept    = valid_i & ready_o;
  assign {col_valid_o, row_valid_o} = sel_onehot & {sel_n_lp{accept}};
  assign row_o     = {array_height_p{data_i}};
  assign col_o     = {array_width_p{data_i}};

  assign valid_o       = live & (state_q == DRAIN_S);
  assign yumi_ok       = yumi_i & valid_o;
  assign data_o        = (state_q == DRAIN_S) ? z_arr[idx_q] : '0;
  assign busy_o        = (state_q != IDLE_S);
  assign array_reset_o = live & (state_q == CLEAR_S);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE_S;
      step_q   <= '0;
      settle_q <= '0;
      idx_q    <= '0;
    end else if (en_i) begin
      state_q  <= state_n;
      step_q   <= step_n;
      settle_q <= settle_n;
      idx_q    <= idx_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    step_n   = step_q;
    settle_n = settle_q;
    idx_n    = idx_q;
    sel_adv  = 1'b0;
    sel_clr  = 1'b0;
    unique case (state_q)
      IDLE_S, LOAD_S: begin
        if (accept) begin
          sel_adv = 1'b1;
          state_n = LOAD_S;
          if (sel_last) begin
            if (step_q == step_w_lp'(depth_p - 1)) begin
              step_n   = '0;
              settle_n = settle_w_lp'(settle_p - 1);
              state_n  = SETTLE_S;
            end else begin
              step_n = step_q + step_w_lp'(1);
            end
          end
        end
      end
      SETTLE_S: begin
        if (settle_q == '0) begin
          state_n = DRAIN_S;
        end else begin
          settle_n = settle_q - settle_w_lp'(1);
        end
      end
      DRAIN_S: begin
        if (yumi_ok) begin
          if (idx_q == idx_w_lp'(num_lp - 1)) begin
            idx_n   = '0;
            state_n = CLEAR_S;
          end else begin
            idx_n = idx_q + idx_w_lp'(1);
          end
        end
      end
      CLEAR_S: begin
        state_n  = IDLE_S;
        step_n   = '0;
        settle_n = '0;
        idx_n    = '0;
        sel_clr  = 1'b1;
      end
      default: state_n = IDLE_S;
    endcase
    // Abort overrides everything; a handshake completed this cycle is dropped.
    if (flush_i) begin
      state_n  = CLEAR_S;
      step_n   = '0;
      settle_n = '0;
      idx_n    = '0;
      sel_adv  = 1'b0;
      sel_clr  = 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_stream_driver.sv
// Directed bench: 2x2/depth-2 and 3-column x 2-row/depth-3 drivers feeding behavioural MAC arrays.
module tb_systolic_stream_driver;

  localparam int unsigned S2 = 8;
  localparam int unsigned S3 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        en2, flush2, valid2, ready2, vo2, yumi2, busy2, arst2;
  logic [31:0] din2, dout2;
  logic [63:0] row2, col2;
  logic [1:0]  rv2, rr2, cv2, cr2;
  logic [127:0] z2;

  logic        en3, flush3, valid3, ready3, vo3, yumi3, busy3, arst3;
  logic [31:0] din3, dout3;
  logic [63:0] row3;
  logic [95:0] col3;
  logic [1:0]  rv3, rr3;
  logic [2:0]  cv3, cr3;
  logic [191:0] z3;

  systolic_stream_driver #(.width_p(32), .array_width_p(2), .array_height_p(2),
                           .depth_p(2), .settle_p(S2)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .en_i(en2), .flush_i(flush2),
    .valid_i(valid2), .ready_o(ready2), .data_i(din2),
    .valid_o(vo2), .yumi_i(yumi2), .data_o(dout2), .busy_o(busy2),
    .row_o(row2), .row_valid_o(rv2), .row_ready_i(rr2),
    .col_o(col2), .col_valid_o(cv2), .col_ready_i(cr2),
    .z_i(z2), .array_reset_o(arst2)
  );

  systolic_stream_driver #(.width_p(32), .array_width_p(3), .array_height_p(2),
                           .depth_p(3), .settle_p(S3)) u_dut3 (
    .clk_i(clk), .reset_i(reset), .en_i(en3), .flush_i(flush3),
    .valid_i(valid3), .ready_o(ready3), .data_i(din3),
    .valid_o(vo3), .yumi_i(yumi3), .data_o(dout3), .busy_o(busy3),
    .row_o(row3), .row_valid_o(rv3), .row_ready_i(rr3),
    .col_o(col3), .col_valid_o(cv3), .col_ready_i(cr3),
    .z_i(z3), .array_reset_o(arst3)
  );

  // Behavioural MAC arrays: rows latch A, each column word accumulates a*b down its column.
  logic [31:0] a2 [2];
  logic [31:0] acc2 [2][2];
  always @(posedge clk) begin
    if (reset || arst2) begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) acc2[i][j] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) if (rv2[i]) a2[i] <= row2[i*32 +: 32];
      for (int j = 0; j < 2; j++)
        if (cv2[j]) for (int i = 0; i < 2; i++) acc2[i][j] <= acc2[i][j] + a2[i] * col2[j*32 +: 32];
    end
  end
  always_comb for (int e = 0; e < 4; e++) z2[e*32 +: 32] = acc2[e/2][e%2];

  logic [31:0] a3 [2];
  logic [31:0] acc3 [2][3];
  always @(posedge clk) begin
    if (reset || arst3) begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) acc3[i][j] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) if (rv3[i]) a3[i] <= row3[i*32 +: 32];
      for (int j = 0; j < 3; j++)
        if (cv3[j]) for (int i = 0; i < 2; i++) acc3[i][j] <= acc3[i][j] + a3[i] * col3[j*32 +: 32];
    end
  end
  always_comb for (int e = 0; e < 6; e++) z3[e*32 +: 32] = acc3[e/3][e%3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [1:0]  rv;
    logic [1:0]  cv;
  } lvec_t;
  lvec_t       lv [8];
  logic [31:0] exp2 [4];

  task automatic load2(input int n_words, input int stall);
    for (int i = 0; i < n_words; i++) begin
      valid2 = 1'b1;
      din2   = lv[i].word;
      if (i == 3 && stall > 0) begin
        cr2[1] = 1'b0;
        for (int c = 0; c < stall; c++) begin
          #1;
          chk("bp_ready", 64'(ready2), 64'd0);
          chk("bp_strobe", 64'({rv2, cv2}), 64'd0);
          @(posedge clk); @(negedge clk);
        end
        cr2[1] = 1'b1;
      end
      #1;
      chk("ld_ready", 64'(ready2), 64'd1);
      chk("ld_row_valid", 64'(rv2), 64'(lv[i].rv));
      chk("ld_col_valid", 64'(cv2), 64'(lv[i].cv));
      chk("ld_col_data", col2, {lv[i].word, lv[i].word});
      chk("ld_row_data", row2, {lv[i].word, lv[i].word});
      @(posedge clk); @(negedge clk);
    end
    valid2 = 1'b0;
  endtask

  task automatic settle2(input bit freeze);
    int k = 0;
    valid2 = 1'b1;
    #1;
    chk("settle_no_accept", 64'({ready2, rv2, cv2}), 64'd0);
    valid2 = 1'b0;
    while (!vo2 && k < 64) begin
      if (freeze && k == 2) begin
        en2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); @(negedge clk); #1;
          chk("freeze_valid", 64'(vo2), 64'd0);
          chk("freeze_busy", 64'(busy2), 64'd1);
        end
        en2 = 1'b1;
        #1;
      end
      @(posedge clk); k++; @(negedge clk); #1;
    end
    chk("settle_cycles", 64'(k), 64'(S2));
  endtask

  task automatic drain2(input int stall_idx, input int stall_n);
    yumi2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_idx) begin
        yumi2 = 1'b0;
        for (int c = 0; c < stall_n; c++) begin
          #1;
          chk("stall_valid", 64'(vo2), 64'd1);
          chk("stall_data", 64'(dout2), 64'(exp2[k]));
          @(posedge clk); @(negedge clk);
        end
        yumi2 = 1'b1;
      end
      #1;
      chk("drain_valid", 64'(vo2), 64'd1);
      chk("drain_data", 64'(dout2), 64'(exp2[k]));
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("clear_pulse", 64'(arst2), 64'd1);
    chk("clear_valid", 64'(vo2), 64'd0);
    chk("clear_data", 64'(dout2), 64'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("clear_done", 64'(arst2), 64'd0);
    chk("idle_busy", 64'(busy2), 64'd0);
  endtask

  logic [31:0] am [2][3];
  logic [31:0] bm [3][3];
  logic [31:0] cref [2][3];

  task automatic send3(input logic [31:0] w, input logic [1:0] erv, input logic [2:0] ecv);
    valid3 = 1'b1;
    din3   = w;
    #1;
    chk("d3_ready", 64'(ready3), 64'd1);
    chk("d3_row_valid", 64'(rv3), 64'(erv));
    chk("d3_col_valid", 64'(cv3), 64'(ecv));
    @(posedge clk); @(negedge clk);
    valid3 = 1'b0;
  endtask

  task automatic job3_load();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        cref[i][j] = '0;
        for (int k = 0; k < 3; k++) cref[i][j] += am[i][k] * bm[k][j];
      end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) send3(am[i][k], 2'(1 << i), 3'd0);
      for (int j = 0; j < 3; j++) send3(bm[k][j], 2'd0, 3'(1 << j));
    end
    begin
      int k = 0;
      while (!vo3 && k < 64) begin
        @(posedge clk); k++; @(negedge clk); #1;
      end
      chk("d3_settle", 64'(k), 64'(S3));
    end
  endtask

  task automatic drain3(input int n);
    yumi3 = 1'b1;
    for (int r = 0; r < n; r++) begin
      #1;
      chk("d3_valid", 64'(vo3), 64'd1);
      chk("d3_data", 64'(dout3), 64'(cref[r/3][r%3]));
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic rand3();
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) am[i][k] = $urandom_range(0, 1000);
    for (int k = 0; k < 3; k++) for (int j = 0; j < 3; j++) bm[k][j] = $urandom_range(0, 1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    lv[0] = '{32'd1, 2'b01, 2'b00};
    lv[1] = '{32'd3, 2'b10, 2'b00};
    lv[2] = '{32'd5, 2'b00, 2'b01};
    lv[3] = '{32'd6, 2'b00, 2'b10};
    lv[4] = '{32'd2, 2'b01, 2'b00};
    lv[5] = '{32'd4, 2'b10, 2'b00};
    lv[6] = '{32'd7, 2'b00, 2'b01};
    lv[7] = '{32'd8, 2'b00, 2'b10};
    exp2[0] = 32'd19; exp2[1] = 32'd22; exp2[2] = 32'd43; exp2[3] = 32'd50;

    reset = 1'b1;
    en2 = 1'b1; flush2 = 1'b0; valid2 = 1'b0; din2 = '0; yumi2 = 1'b1; rr2 = 2'b11; cr2 = 2'b11;
    en3 = 1'b1; flush3 = 1'b0; valid3 = 1'b0; din3 = '0; yumi3 = 1'b1; rr3 = 2'b11; cr3 = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_valid", 64'(vo2), 64'd0);
    chk("rst_arst", 64'(arst2), 64'd0);
    chk("rst_data", 64'(dout2), 64'd0);
    chk("rst_strobe", 64'({rv2, cv2}), 64'd0);
    chk("rst_ready", 64'(ready2), 64'd1);
    en2 = 1'b0; valid2 = 1'b1;
    #1;
    chk("en_low_ready", 64'(ready2), 64'd0);
    chk("en_low_strobe", 64'({rv2, cv2}), 64'd0);
    valid2 = 1'b0; en2 = 1'b1;

    // Baseline job, then one job with column stall, settle freeze and drain stall.
    load2(8, 0); settle2(1'b0); drain2(-1, 0);
    load2(8, 5); settle2(1'b1); drain2(2, 3);

    // Abort after three words, then a clean job.
    load2(3, 0);
    flush2 = 1'b1;
    @(posedge clk); @(negedge clk);
    flush2 = 1'b0;
    #1;
    chk("flush_pulse", 64'(arst2), 64'd1);
    chk("flush_busy", 64'(busy2), 64'd1);
    chk("flush_ready", 64'(ready2), 64'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("flush_done", 64'(arst2), 64'd0);
    chk("flush_idle", 64'(busy2), 64'd0);
    @(negedge clk);
    load2(8, 0); settle2(1'b0); drain2(-1, 0);

    // Wider array: full job, then reset in the middle of the drain.
    rand3();
    job3_load();
    drain3(6);
    #1;
    chk("d3_clear", 64'(arst3), 64'd1);
    @(posedge clk); @(negedge clk); #1;
    chk("d3_idle", 64'(busy3), 64'd0);
    @(negedge clk);
    rand3();
    job3_load();
    drain3(2);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("d3_rst_valid", 64'(vo3), 64'd0);
    chk("d3_rst_busy", 64'(busy3), 64'd0);
    chk("d3_rst_arst", 64'(arst3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_stream_driver.md
Name: systolic_stream_driver

Overview:
- Parametrised stream front-end for the systolic array (any array_width_p x array_height_p, any inner dimension depth_p).
- Accepts one operand word per handshake on a ready/valid consumer port and routes each word to exactly one row or column input of the array.
- Waits a programmable settle time, drains every MAC result in order over a valid/yumi producer port, then clears the array for the next matrix pair.
- Adds per-word backpressure, generic output indexing, abort-flush, and a clean drain handshake.

Parameters:
- width_p, 32, data word width.
- array_width_p, 2, array columns (column inputs).
- array_height_p, 2, array rows (row inputs).
- depth_p, 2, inner dimension K: number of operand steps per matrix pair.
- settle_p, 8, cycles waited after the last operand before results are read; must be >= 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- en_i  in  1  global enable; when low, all state, counters and handshakes are frozen and ready_o/valid_o are forced 0.
- flush_i  in  1  abort the current job; go to CLEAR_S.
- valid_i  in  1  operand word valid.
- ready_o  out  1  operand word accepted when valid_i & ready_o.
- data_i  in  width_p  operand word.
- valid_o  out  1  result word valid.
- yumi_i  in  1  result consumed; legal only while valid_o is high.
- data_o  out  width_p  result word.
- busy_o  out  1  high in any state other than IDLE_S.
- row_o  out  width_p*array_height_p  data_i replicated to every row.
- row_valid_o  out  array_height_p  one-hot row strobe.
- row_ready_i  in  array_height_p  row consumer ready.
- col_o  out  width_p*array_width_p  data_i replicated to every column.
- col_valid_o  out  array_width_p  one-hot column strobe.
- col_ready_i  in  array_width_p  column consumer ready.
- z_i  in  width_p*array_width_p*array_height_p  MAC results; element i is row i/array_width_p, column i%array_width_p, at bits [i*width_p +: width_p].
- array_reset_o  out  1  reset to the array.

Behaviour:
- States (one-hot): IDLE_S, LOAD_S, SETTLE_S, DRAIN_S, CLEAR_S.
- Reset: state IDLE_S, all counters 0. ready_o=0 until the first enabled cycle after reset. valid_o=0, busy_o=0, strobes 0, array_reset_o=0.
- Word order within each step k: the array_height_p row words (row 0 first), then the array_width_p column words (column 0 first). Consumer select counter sel runs 0..array_height_p+array_width_p-1.
- ready_o = en_i & (IDLE_S|LOAD_S) & ready of the selected consumer.
- Strobe for the selected consumer = valid_i & ready_o, asserted combinationally in the same cycle. At most one strobe is high; all are 0 otherwise.
- On each accept, sel increments. On wrap, sel returns to 0 and the step counter increments.
- IDLE_S -> LOAD_S on the first accept.
- LOAD_S -> SETTLE_S on the accept with sel at its last value and step = depth_p-1. No further words are accepted until IDLE_S.
- SETTLE_S: down-counter loaded with settle_p-1. Move to DRAIN_S when it reaches 0, so DRAIN_S is entered exactly settle_p cycles after the last accept.
- DRAIN_S: valid_o=1 and data_o = z_i element idx, with idx starting at 0.
  - On yumi_i, idx increments.
  - yumi_i at idx = N-1 (N = array_width_p*array_height_p) moves to CLEAR_S.
  - data_o is 0 outside DRAIN_S.
- CLEAR_S: array_reset_o=1 for exactly one cycle, counters clear, then IDLE_S.
- flush_i from any state -> CLEAR_S next cycle; flush_i has priority over every other transition.
  - An accept or yumi in the same cycle as flush_i is still honoured at the port (the handshake completed), but the counters are discarded.
- reset_i has priority over flush_i and en_i.
- reset_i mid-job: return to IDLE_S without pulsing array_reset_o. The array shares reset_i.
- Counter widths: $clog2 of each range, minimum 1 bit.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum state_e (one-hot).
  - Helper function idx_width(n) returning max(1, $clog2(n)).
- One natural sub-module: onehot_counter, reused to drive the consumer select. The row/column strobe vector is onehot & {valid_i & ready_o}.

Test Plan:
- 2x2, depth 2, with a behavioural MAC-array model.
  - Stimulus: words 1,3,5,6 then 2,4,7,8 (A=[[1,2],[3,4]], B=[[5,6],[7,8]]), with yumi_i always high.
  - Required: data_o sequence 19,22,43,50, then a one-cycle array_reset_o pulse, then IDLE_S.
- Backpressure: col_ready_i[1]=0 for 5 cycles while sel selects column 1.
  - Required: ready_o=0 and no strobe during the stall; the word is accepted on the first ready cycle; results unchanged.
- Drain stall: yumi_i low for 3 cycles at idx=2.
  - Required: valid_o stays 1 and data_o holds 43; the next value appears only after yumi_i.
- Flush after 3 accepted words.
  - Required: array_reset_o pulses the next cycle; the next full job still produces 19,22,43,50.
- en_i low for 4 cycles in SETTLE_S.
  - Required: the settle count freezes, and valid_o rises exactly settle_p enabled cycles after the last accept.
- 3x2, depth 3, random data against a reference matrix multiply.
  - Required: 6 results in row-major order; reset_i mid-DRAIN_S returns to IDLE_S with valid_o=0 the next cycle.
